// File: rtl/isp_src_pkg.sv
// Shared types and constants for the CCD frame source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package isp_src_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_LINE   = 2'd2,
    S_HBLANK = 2'd3
  } src_state_t;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_COORD = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  localparam int DEF_WIDTH  = 322;
  localparam int DEF_HEIGHT = 242;
  localparam int DEF_HBLANK = 16;
  localparam int DEF_VBLANK = 64;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/src_pattern_gen.sv
// Pattern word selection: ramp, {row,col} coordinate or constant.
// Latency: combinational; the caller registers the result.
// Backpressure: none; evaluated every cycle.
// Ports: i_row/i_col position, i_pix pixel index in frame, i_mode pattern,
//        i_const constant word, o_word selected pixel word.
module src_pattern_gen
  import isp_src_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [15:0]       i_row,
  input  logic [15:0]       i_col,
  input  logic [31:0]       i_pix,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_const,
  output logic [DATA_W-1:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_mode)
      MODE_COORD: o_word[31:0] = {i_row, i_col};
      MODE_CONST: o_word = i_const;
      // MODE_RAMP and the spare encoding 3 both produce the ramp
      default:    o_word[31:0] = i_pix + 32'd1;
    endcase
  end

endmodule

// File: rtl/ccd_frame_source.sv
// Camera frame source: padded WIDTHxHEIGHT frames with line/frame valids.
// Latency: start sampled at edge N -> first word at edge N+1+VBLANK.
// Backpressure: none (camera cannot stall); write_full only sets sticky overflow.
// Ports: clk/reset, start/continuous/stop control, mode/const_data pattern,
//        write_full monitor; oDVAL/oLVAL/oFVAL/oData stream, new_frame,
//        busy, frame_count, overflow status.
module ccd_frame_source
  import isp_src_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int HBLANK = DEF_HBLANK,
  parameter int VBLANK = DEF_VBLANK,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_data,
  input  logic              write_full,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oData,
  output logic              oLVAL,
  output logic              oFVAL,
  output logic              new_frame,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              overflow
);

  localparam logic [15:0] W_LAST  = 16'(WIDTH - 1);
  localparam logic [15:0] H_LAST  = 16'(HEIGHT - 1);
  localparam logic [15:0] HB_LAST = 16'(HBLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(VBLANK - 1);

  src_state_t        r_state;
  src_state_t        w_state_nx;
  logic [15:0]       r_bcnt;
  logic [15:0]       r_col;
  logic [15:0]       r_row;
  logic [31:0]       r_pix;
  logic [1:0]        r_mode;
  logic              r_stop_pend;
  logic              w_eol;
  logic              w_eof;
  logic [DATA_W-1:0] w_word;

  assign w_eol = (r_col == W_LAST);
  assign w_eof = w_eol && (r_row == H_LAST);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_VBLANK;
      S_VBLANK: if (r_bcnt == VB_LAST) w_state_nx = S_LINE;
      S_LINE: begin
        if (w_eol) begin
          if (!w_eof)
            w_state_nx = S_HBLANK;
          // a stop arriving on the last word counts as pending too
          else if (continuous && !(r_stop_pend || stop))
            w_state_nx = S_VBLANK;
          else
            w_state_nx = S_IDLE;
        end
      end
      S_HBLANK: if (r_bcnt == HB_LAST) w_state_nx = S_LINE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  src_pattern_gen #(.DATA_W(DATA_W)) u_pat (
    .i_row   (r_row),
    .i_col   (r_col),
    .i_pix   (r_pix),
    .i_mode  (r_mode),
    .i_const (const_data),
    .o_word  (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bcnt      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_pix       <= '0;
      r_mode      <= MODE_RAMP;
      r_stop_pend <= 1'b0;
      oDVAL       <= 1'b0;
      oData       <= '0;
      oLVAL       <= 1'b0;
      oFVAL       <= 1'b0;
      new_frame   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      // busy follows the state register exactly, not one cycle behind it
      busy    <= (w_state_nx != S_IDLE);

      // stream outputs are a registered image of the current state/position
      oDVAL     <= (r_state == S_LINE);
      oLVAL     <= (r_state == S_LINE);
      oFVAL     <= (r_state == S_LINE) || (r_state == S_HBLANK);
      oData     <= (r_state == S_LINE) ? w_word : '0;
      new_frame <= (r_state == S_LINE) && (r_row == '0) && (r_col == '0);

      // compares the word currently on the bus with the FIFO-full flag
      if (oDVAL && write_full) overflow <= 1'b1;

      if ((r_state != S_IDLE) && stop) r_stop_pend <= 1'b1;

      case (r_state)
        S_IDLE: r_bcnt <= '0;
        S_VBLANK: begin
          if (r_bcnt == VB_LAST) begin
            r_bcnt <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_pix  <= '0;
            r_mode <= mode;
          end else begin
            r_bcnt <= r_bcnt + 16'd1;
          end
        end
        S_LINE: begin
          r_pix <= r_pix + 32'd1;
          if (w_eol) begin
            r_col  <= '0;
            r_bcnt <= '0;
            if (w_eof) begin
              frame_count <= frame_count + 16'd1;
              r_stop_pend <= 1'b0;
            end
          end else begin
            r_col <= r_col + 16'd1;
          end
        end
        S_HBLANK: begin
          if (r_bcnt == HB_LAST) begin
            r_bcnt <= '0;
            r_row  <= r_row + 16'd1;
          end else begin
            r_bcnt <= r_bcnt + 16'd1;
          end
        end
        default: r_bcnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/ccd_frame_source.md
Name: ccd_frame_source

Overview:
- Cycle-accurate source of camera pixel frames: the transmitter side of the pixel-valid/data stream that the frame-buffer bus consumes on its write port.
- Emits a padded frame of WIDTH×HEIGHT 32-bit words with line/frame valids and blanking.
- Used as a stand-in for the D5M capture path in bus/ISP benches and as an on-board test-pattern injector ahead of the write FIFO.
- Also monitors the write-FIFO full flag and records overflow.

Parameters:
- WIDTH, 322: words per line (320 active + 2 padding).
- HEIGHT, 242: lines per frame (240 active + 2 padding).
- HBLANK, 16: idle cycles between lines; must be ≥1.
- VBLANK, 64: idle cycles before each frame's first line; must be ≥1.
- DATA_W, 32: pixel word width; must be ≥32.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE, begins a frame.
- continuous  in  1  1 = loop frames until stop; 0 = single frame.
- stop  in  1  pulse; finish current frame then IDLE.
- mode  in  2  pattern select: 0 ramp, 1 coordinate, 2 constant, 3 ramp.
- const_data  in  DATA_W  word used in mode 2.
- write_full  in  1  write-FIFO full from bus.
- oDVAL  out  1  pixel valid (sCCD_DVAL equivalent).
- oData  out  DATA_W  pixel word.
- oLVAL  out  1  high for every word of a line.
- oFVAL  out  1  high from first word of line 0 to last word of last line, including inter-line HBLANK.
- new_frame  out  1  one-cycle pulse with the first word of each frame.
- busy  out  1  state != IDLE.
- frame_count  out  16  completed frames, wraps at 0xFFFF→0.
- overflow  out  1  sticky: oDVAL=1 while write_full=1.

Behaviour:
- All outputs registered.
- Reset: state IDLE; all outputs 0; counters 0; stop_pend 0.
- States: IDLE, VBLANK, LINE, HBLANK.
- IDLE: start=1 → VBLANK, vcnt=0. start=0 → stay.
- VBLANK: runs VBLANK cycles, then LINE with col=0, row=0.
- LINE: one word per cycle, col 0..WIDTH-1.
  - At col=WIDTH-1 and row<HEIGHT-1 → HBLANK.
  - At col=WIDTH-1 and row=HEIGHT-1 → end of frame; frame_count+1 on that edge.
- End of frame:
  - continuous=1 and no stop pending → VBLANK.
  - Otherwise → IDLE and clear stop_pend.
- HBLANK: runs HBLANK cycles, then LINE with row+1, col=0.
- Latency: start sampled at edge N → first oDVAL=1 at edge N+1+VBLANK, together with new_frame=1.
- oDVAL = oLVAL = 1 exactly in LINE; 0 in blanking.
- oData is 0 whenever oDVAL=0.
- Patterns:
  - mode 0/3: ramp = pixel index within frame + 1, so 1..WIDTH×HEIGHT; restarts at 1 each frame; upper bits zero.
  - mode 1: {row[15:0], col[15:0]}, zero-extended to DATA_W.
  - mode 2: const_data.
- mode is sampled at frame start (VBLANK→LINE) and held for the whole frame.
- stop:
  - In any non-IDLE state it sets stop_pend; the current frame completes fully.
  - stop in IDLE is ignored.
  - stop and start together in IDLE: start wins.
- continuous is sampled at end of frame, not at start.
- overflow: set when oDVAL=1 and write_full=1 on the same edge; cleared only by reset. The word is still emitted (the camera cannot stall).
- Reset mid-frame: the next edge returns to IDLE with outputs 0; no partial new_frame.

Decomposition:
- Package isp_src_pkg:
  - state enum {IDLE, VBLANK, LINE, HBLANK}.
  - mode encodings MODE_RAMP=0, MODE_COORD=1, MODE_CONST=2.
  - Default geometry constants.
- Sub-module src_pattern_gen:
  - Combinational/registered word selection from row, col, ramp counter, mode and const_data.
  - Keeps the FSM/counter logic separate.

Test Plan (WIDTH=4, HEIGHT=3, HBLANK=2, VBLANK=3):
- Single frame ramp: start pulse at edge 10, continuous=0, mode 0.
  - new_frame at edge 14.
  - Words 1,2,3,4 / gap 2 / 5..8 / gap 2 / 9..12.
  - oFVAL high edges 14–29.
  - frame_count=1, busy=0 at edge 30.
- Continuous coordinate: mode 1, continuous=1.
  - Frame 0 line 1 words = 0x00010000..0x00010003.
  - 3-cycle VBLANK between frames.
  - Ramp restarts and frame_count increments per frame.
- Stop mid-frame: stop pulse during row 1.
  - Remaining words through 12 still emitted, then IDLE.
  - No further new_frame.
  - stop in IDLE has no effect.
- Overflow: write_full=1 on the cycle of word 6 → overflow=1 from the next cycle and stays 1. A second overflow leaves it 1. Reset clears it.
- Reset mid-line at word 2: next cycle all outputs 0, IDLE. A fresh start then restarts at word 1 with new_frame.
- Mode change mid-frame: switch mode 0→2 with const_data=0xDEADBEEF during row 0. The current frame stays ramp; the next frame is all 0xDEADBEEF.
